// File: rtl/vs_codec_responder_if.sv
// Serial pins between an mp3 controller (master) and the VS10xx responder (slave).
interface vs_codec_responder_if;
  logic i_XCS;
  logic i_XDCS;
  logic i_SCK;
  logic i_SI;
  logic i_XRST;
  logic o_DREQ;
  logic o_SO;

  modport master (output i_XCS, i_XDCS, i_SCK, i_SI, i_XRST, input o_DREQ, o_SO);
  modport slave  (input i_XCS, i_XDCS, i_SCK, i_SI, i_XRST, output o_DREQ, o_SO);
endinterface

// File: rtl/vs_codec_responder.sv
// VS10xx serial-side responder: SCI register file, SDI byte FIFO with a fixed-rate
// playback drain, DREQ flow control and MODE-triggered soft reset.
module vs_codec_responder #(
  parameter int FIFO_DEPTH  = 32,
  parameter int DREQ_MARGIN = 4,
  parameter int DRAIN_DIV   = 16,
  parameter int INIT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  vs_codec_responder_if.slave           bus,
  output logic [15:0]                   o_mode,
  output logic [15:0]                   o_vol,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [31:0]                   o_sdi_bytes,
  output logic [15:0]                   o_sci_writes,
  output logic                          o_overflow,
  output logic                          o_err
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(DRAIN_DIV + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MARGIN_L  = LW'(DREQ_MARGIN);
  localparam logic [DW-1:0] DRAIN_RLD = DW'(DRAIN_DIV - 1);
  localparam logic [IW-1:0] INIT_LD   = IW'(INIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCI  = 2'd1;
  localparam logic [1:0] ST_SDI  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0] xcs_q, xdcs_q, sck_q, si_q, xrst_q;
  logic       sck_prev_q;

  // The XRST chain is cleared only by rst so that it can always observe its own release.
  always_ff @(posedge clk) begin
    if (rst) begin
      xcs_q      <= 2'b11;
      xdcs_q     <= 2'b11;
      xrst_q     <= 2'b11;
      sck_q      <= 2'b00;
      si_q       <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      xcs_q      <= {xcs_q[0], bus.i_XCS};
      xdcs_q     <= {xdcs_q[0], bus.i_XDCS};
      xrst_q     <= {xrst_q[0], bus.i_XRST};
      sck_q      <= {sck_q[0], bus.i_SCK};
      si_q       <= {si_q[0], bus.i_SI};
      sck_prev_q <= sck_q[1];
    end
  end

  logic xcs_s, xdcs_s, si_s, rst_int, sck_rise, sck_fall;
  assign xcs_s    = xcs_q[1];
  assign xdcs_s   = xdcs_q[1];
  assign si_s     = si_q[1];
  assign rst_int  = rst | ~xrst_q[1];
  assign sck_rise = sck_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_q[1] & sck_prev_q;

  logic [1:0]    state_q, state_d;
  logic [4:0]    bit_cnt_q;
  logic [30:0]   shift_q;
  logic [15:0]   regs_q [16];
  logic [15:0]   rdata_q;
  logic          rd_act_q, so_q, dreq_q, soft_q, ovf_q, err_q;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] drain_q;
  logic [IW-1:0] init_q;
  logic [31:0]   sdi_bytes_q;
  logic [15:0]   sci_writes_q;

  logic        both_low, in_frame, sci_bit, sdi_bit, bit_en, sci_last, sdi_last;
  logic        commit, reg_we, soft_go, rd_hdr, full, push_ok, pop, soft_end, dreq_d;
  logic [7:0]  w_op, w_addr, rd_addr;
  logic [15:0] w_data, rd_word;

  assign both_low = ~xcs_s & ~xdcs_s;
  assign in_frame = (state_q == ST_SCI) || (state_q == ST_SDI);
  assign sci_bit  = (state_q == ST_SCI) & ~xcs_s & xdcs_s & sck_rise;
  assign sdi_bit  = (state_q == ST_SDI) & ~xdcs_s & xcs_s & sck_rise;
  assign bit_en   = sci_bit | sdi_bit;
  assign sci_last = sci_bit & (bit_cnt_q == 5'd31);
  assign sdi_last = sdi_bit & (bit_cnt_q[2:0] == 3'd7);

  // The 32nd bit completes the frame combinationally so the commit lands on its capture edge.
  assign w_op    = shift_q[30:23];
  assign w_addr  = shift_q[22:15];
  assign w_data  = {shift_q[14:0], si_s};
  assign commit  = sci_last & (w_op == 8'h02);
  assign reg_we  = commit & (w_addr[7:4] == 4'h0);
  assign soft_go = reg_we & (w_addr[3:0] == 4'h0) & w_data[2];

  assign rd_addr = {shift_q[6:0], si_s};
  assign rd_hdr  = sci_bit & (bit_cnt_q == 5'd15) & (shift_q[14:7] == 8'h03);
  assign rd_word = (rd_addr[7:4] == 4'h0) ? regs_q[rd_addr[3:0]] : 16'h0000;

  // Played-back bytes are discarded, so the FIFO reduces to its occupancy.
  assign full     = (level_q == DEPTH_L);
  assign push_ok  = sdi_last & ~full;
  assign pop      = (drain_q == '0) && (level_q != '0);
  assign soft_end = soft_q && (init_q == '0);
  assign dreq_d   = (init_q == '0) && !soft_q && ((DEPTH_L - level_q) >= MARGIN_L);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (!push_ok && pop) level_d = level_q - LW'(1);
    if (soft_go)              level_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (both_low) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE: if (!xcs_s) state_d = ST_SCI;
                 else if (!xdcs_s && !soft_q) state_d = ST_SDI;
        ST_SCI:  if (xcs_s) state_d = ST_IDLE;
        ST_SDI:  if (xdcs_s) state_d = ST_IDLE;
        default: if (xcs_s && xdcs_s) state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rdata_q      <= '0;
      rd_act_q     <= 1'b0;
      so_q         <= 1'b0;
      dreq_q       <= 1'b0;
      level_q      <= '0;
      drain_q      <= DRAIN_RLD;
      init_q       <= INIT_LD;
      soft_q       <= 1'b0;
      sdi_bytes_q  <= '0;
      sci_writes_q <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || !in_frame) bit_cnt_q <= '0;
      else if (bit_en)                     bit_cnt_q <= bit_cnt_q + 5'd1;
      if (bit_en) shift_q <= {shift_q[29:0], si_s};

      level_q <= level_d;
      drain_q <= (drain_q == '0) ? DRAIN_RLD : drain_q - DW'(1);
      dreq_q  <= dreq_d;

      if (soft_go)             init_q <= INIT_LD;
      else if (init_q != '0)   init_q <= init_q - IW'(1);
      if (soft_go)             soft_q <= 1'b1;
      else if (soft_end)       soft_q <= 1'b0;
      if (soft_end)            regs_q[0][2] <= 1'b0;
      if (reg_we)              regs_q[w_addr[3:0]] <= w_data;

      if (sdi_last)            sdi_bytes_q  <= sdi_bytes_q + 32'd1;
      if (sdi_last && full)    ovf_q        <= 1'b1;
      if (commit)              sci_writes_q <= sci_writes_q + 16'd1;
      if (both_low)            err_q        <= 1'b1;

      if (state_q != ST_SCI || sci_last) begin
        rd_act_q <= 1'b0;
        so_q     <= 1'b0;
      end else if (rd_hdr) begin
        rd_act_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rd_act_q && sck_fall) begin
        so_q    <= rdata_q[15];
        rdata_q <= {rdata_q[14:0], 1'b0};
      end
    end
  end

  assign bus.o_DREQ   = dreq_q;
  assign bus.o_SO     = so_q;
  assign o_mode       = regs_q[0];
  assign o_vol        = regs_q[11];
  assign o_fifo_level = level_q;
  assign o_sdi_bytes  = sdi_bytes_q;
  assign o_sci_writes = sci_writes_q;
  assign o_overflow   = ovf_q;
  assign o_err        = err_q;
endmodule
